// File: rtl/sync_filt_pkg.sv
// rtl/sync_filt_pkg.sv - shared defaults and edge pulse struct for sync_filt
package sync_filt_pkg;
    localparam int SYNC_W_DEF = 2;
    localparam int FILT_W_DEF = 4;
    localparam int DW_DEF     = 8;

    typedef struct packed {
        logic pos;
        logic neg;
    } edge_t;
endpackage

// File: rtl/sync_filt_if.sv
// rtl/sync_filt_if.sv - parallel input / filtered output bundle for sync_filt
interface sync_filt_if #(
    parameter int DW     = 8,
    parameter int FILT_W = 4
);
    logic [DW-1:0]     pdi;
    logic              filt_en;
    logic [FILT_W-1:0] filt_lim;
    logic [DW-1:0]     pdo;
    logic [DW-1:0]     pos;
    logic [DW-1:0]     neg;
    logic              any_chg;

    modport master (output pdi, filt_en, filt_lim, input pdo, pos, neg, any_chg);
    modport slave  (input pdi, filt_en, filt_lim, output pdo, pos, neg, any_chg);
endinterface

// File: rtl/sync_filt_ch.sv
// rtl/sync_filt_ch.sv - one channel: flop synchroniser, glitch filter, edge pulses
module sync_filt_ch
    import sync_filt_pkg::*;
#(
    parameter int   SYNC_W  = SYNC_W_DEF,
    parameter int   FILT_W  = FILT_W_DEF,
    parameter logic RST_BIT = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_d,
    input  logic              i_filt_en,
    input  logic [FILT_W-1:0] i_filt_lim,
    output logic              o_pdo,
    output edge_t             o_edge,
    output logic              o_chg
);
    logic [SYNC_W-1:0] r_sync;
    logic              r_pdo;
    logic [FILT_W-1:0] r_cnt;
    edge_t             r_edge;
    logic              w_s;
    logic              w_mismatch;

    assign w_s        = r_sync[SYNC_W-1];
    assign w_mismatch = (w_s != r_pdo);
    // Accept when bypassed or the mismatch has persisted past the limit; >= tolerates a lowered limit.
    assign o_chg      = w_mismatch && (!i_filt_en || (r_cnt >= i_filt_lim));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= {SYNC_W{RST_BIT}};
            r_pdo  <= RST_BIT;
            r_cnt  <= '0;
            r_edge <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_W-2:0], i_d};
            r_edge <= '0;
            if (o_chg) begin
                r_pdo      <= w_s;
                r_cnt      <= '0;
                r_edge.pos <= w_s;
                r_edge.neg <= ~w_s;
            end else if (w_mismatch && i_filt_en) begin
                r_cnt <= r_cnt + 1'b1;
            end else begin
                r_cnt <= '0;
            end
        end
    end

    assign o_pdo  = r_pdo;
    assign o_edge = r_edge;
endmodule

// File: rtl/sync_filt.sv
// rtl/sync_filt.sv - DW-channel synchroniser with per-channel glitch filter and edge detect
module sync_filt
    import sync_filt_pkg::*;
#(
    parameter int          SYNC_W  = SYNC_W_DEF,
    parameter int          DW      = DW_DEF,
    parameter int          FILT_W  = FILT_W_DEF,
    parameter logic [DW-1:0] RST_VAL = '0
) (
    input  logic       clk,
    input  logic       rst,
    sync_filt_if.slave bus
);
    logic [DW-1:0] w_pdo;
    logic [DW-1:0] w_pos;
    logic [DW-1:0] w_neg;
    logic [DW-1:0] w_chg;
    logic          r_any_chg;

    for (genvar g = 0; g < DW; g++) begin : g_ch
        edge_t w_edge;

        sync_filt_ch #(
            .SYNC_W  (SYNC_W),
            .FILT_W  (FILT_W),
            .RST_BIT (RST_VAL[g])
        ) u_ch (
            .clk        (clk),
            .rst        (rst),
            .i_d        (bus.pdi[g]),
            .i_filt_en  (bus.filt_en),
            .i_filt_lim (bus.filt_lim),
            .o_pdo      (w_pdo[g]),
            .o_edge     (w_edge),
            .o_chg      (w_chg[g])
        );

        assign w_pos[g] = w_edge.pos;
        assign w_neg[g] = w_edge.neg;
    end

    // Registered from the same accept terms as the channel pulses so it lines up with them.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_any_chg <= 1'b0;
        end else begin
            r_any_chg <= |w_chg;
        end
    end

    assign bus.pdo     = w_pdo;
    assign bus.pos     = w_pos;
    assign bus.neg     = w_neg;
    assign bus.any_chg = r_any_chg;
endmodule

// File: doc/sync_filt.md
SYNC_FILT -- requirements
Module: sync_filt

Interface
REQ-001 Parameter SYNC_W, default 2: number of synchroniser flop stages, legal range 2..4.
REQ-002 Parameter DW, default 8: number of independent input channels.
REQ-003 Parameter FILT_W, default 4: width of the per-channel glitch-filter counter and of filt_lim.
REQ-004 Parameter RST_VAL, default '0: DW-bit value loaded into sync stages and pdo on reset.
REQ-005 clk  in  1  single clock; all state changes on rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 pdi  in  DW  asynchronous parallel inputs.
REQ-008 filt_en  in  1  1 = glitch filter active; 0 = bypass, with filter counters held at 0.
REQ-009 filt_lim  in  FILT_W  filter limit L; an input change must persist L+1 consecutive synced cycles to be accepted.
REQ-010 pdo  out  DW  synchronised, filtered level per channel.
REQ-011 pos  out  DW  one-cycle pulse per channel on an accepted 0->1 change.
REQ-012 neg  out  DW  one-cycle pulse per channel on an accepted 1->0 change.
REQ-013 any_chg  out  1  OR of pos|neg, registered with them.

Function
REQ-014 Sync chain SHALL be SYNC_W flop stages per channel, with no logic between stages; s = last-stage output.
REQ-015 Per channel, mismatch = (s != pdo).
REQ-016 When mismatch and filt_en=1 and cnt >= filt_lim: pdo <= s, cnt <= 0.
REQ-017 When mismatch and filt_en=1 and cnt < filt_lim: cnt <= cnt+1; pdo holds.
REQ-018 When no mismatch: cnt <= 0 (any glitch shorter than L+1 cycles is discarded).
REQ-019 When filt_en=0: pdo <= s on every cycle; cnt <= 0.
REQ-020 Comparison SHALL use >=, so lowering filt_lim mid-count takes effect next cycle without overflow.
REQ-021 cnt SHALL never wrap; it is bounded by filt_lim <= 2^FILT_W-1.
REQ-022 Latency pdi -> pdo SHALL be SYNC_W+L+1 cycles (filt_en=1), and SYNC_W+1 cycles (filt_en=0 or L=0), for a stable input.
REQ-023 pos[i]/neg[i] SHALL be registered alongside the pdo update, high in exactly the first cycle pdo[i] shows the new value, and low otherwise.
REQ-024 Channels SHALL be fully independent; simultaneous changes on several channels produce simultaneous pulses.
REQ-025 Toggling filt_en mid-count SHALL take effect the next cycle; no spurious pulses occur.

Reset
REQ-026 On rst=1 at a clock edge: all sync stages = RST_VAL, pdo = RST_VAL, cnt = 0, pos = neg = 0, any_chg = 0.
REQ-027 Reset mid-filter SHALL discard pending counts; no pulse is generated by reset itself.
REQ-028 After reset release, a pdi differing from RST_VAL SHALL produce a normal pulse after full latency.

Structure
REQ-029 Package sync_filt_pkg SHALL hold default constants (SYNC_W_DEF=2, FILT_W_DEF=4) and a packed struct edge_t {pos, neg}.
REQ-030 Per-channel filter plus edge logic SHALL be the sub-module sync_filt_ch (parameters SYNC_W, FILT_W, RST_BIT), instantiated DW times in a generate loop.
REQ-031 The design SHALL contain no latches and no combinational path from pdi to any output.

Verification
REQ-032 DW=8, SYNC_W=2, filt_en=0, pdi 0x00->0xA5: pdo=0xA5 exactly 3 cycles later; pos=0xA5 for 1 cycle; any_chg=1 for 1 cycle.
REQ-033 filt_en=1, L=3, pdi[0] high for 3 cycles then low: pdo[0] stays 0; pos[0] never asserts.
REQ-034 filt_en=1, L=3, pdi[0] high and held: pdo[0]=1 at cycle 2+3+1=6; pos[0] pulses once; releasing pdi[0] gives neg[0] at release+6.
REQ-035 L=15 with cnt=10, then filt_lim changed to 5: pdo updates on the next cycle; cnt returns to 0; no wrap.
REQ-036 Assert rst for 1 cycle mid-count with RST_VAL=0x0F: next cycle pdo=0x0F and pos=neg=0; with pdi held at 0xF0, pos=0xF0 and neg=0x0F after full latency.
REQ-037 Random async pdi with random filt_en/filt_lim, checked against a reference model: pdo, pos and neg match every cycle, and pos&neg==0 always.
